// File: rtl/cmp_share_arbiter_if.sv
// Requester and comparator-side signals of cmp_share_arbiter.
// slave: the arbiter. master: requesters plus the shared comparator.
interface cmp_share_arbiter_if #(
  parameter int N = 4,
  parameter int W = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           res_lt;
  logic           res_eq;
  logic           res_gt;
  logic           err;
  logic [W-1:0]   cmp_a;
  logic [W-1:0]   cmp_b;
  logic           cmp_lt;
  logic           cmp_eq;
  logic           cmp_gt;

  modport slave (
    input  req, req_a, req_b, cmp_lt, cmp_eq, cmp_gt,
    output gnt, done, res_lt, res_eq, res_gt, err, cmp_a, cmp_b
  );

  modport master (
    output req, req_a, req_b, cmp_lt, cmp_eq, cmp_gt,
    input  gnt, done, res_lt, res_eq, res_gt, err, cmp_a, cmp_b
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Shares one magnitude comparator among N requesters (IDLE -> CMP -> DONE).
// Define CMP_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module cmp_share_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst,
  cmp_share_arbiter_if.slave bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    done_q, done_d;
  logic [2:0]      res_q, res_d;
  logic            err_q, err_d;

  logic            win_vld;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  logic [2:0]      cmp_flags;
  logic            flags_onehot;

  assign cmp_flags    = {bus.cmp_lt, bus.cmp_eq, bus.cmp_gt};
  assign flags_onehot = (^cmp_flags) & ~(&cmp_flags);

  // First asserted request found scanning upward from the start index.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
`ifdef CMP_ARB_FIXED_PRIO_EN
      cand = PW'(k);
`else
      cand = PW'((int'(ptr_q) + k) % N);
`endif
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    gnt_d   = '0;
    done_d  = '0;
    res_d   = '0;
    err_d   = err_q;
    case (state_q)
      CMP: begin
        // gnt_q still names the owner; the result is delivered even if malformed
        res_d   = cmp_flags;
        done_d  = gnt_q;
        err_d   = err_q | ~flags_onehot;
        state_d = DONE;
      end
      IDLE, DONE: begin
        if (win_vld) begin
          op_a_d  = bus.req_a[win_idx*W +: W];
          op_b_d  = bus.req_b[win_idx*W +: W];
          gnt_d   = N'(1) << win_idx;
          state_d = CMP;
`ifdef CMP_ARB_FIXED_PRIO_EN
          ptr_d   = '0;
`else
          ptr_d   = PW'((int'(win_idx) + 1) % N);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.res_lt = res_q[2];
  assign bus.res_eq = res_q[1];
  assign bus.res_gt = res_q[0];
  assign bus.err    = err_q;
  assign bus.cmp_a  = op_a_q;
  assign bus.cmp_b  = op_b_q;
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cmp_share_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fault = 1'b0;
  logic [N-1:0] hold = '0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cmp_share_arbiter_if #(.N(N), .W(W)) ifc ();
  cmp_share_arbiter #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(ifc));

  // Shared comparator; the fault mode returns lt=eq=1.
  assign ifc.cmp_lt = fault | (ifc.cmp_a < ifc.cmp_b);
  assign ifc.cmp_eq = fault | (ifc.cmp_a == ifc.cmp_b);
  assign ifc.cmp_gt = !fault && (ifc.cmp_a > ifc.cmp_b);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a granted op reports its result one cycle later; arbitration
  // happens on any edge that is not the result-capture edge of a grant.
  logic [N-1:0] m_gnt = '0, m_done = '0;
  logic [2:0]   m_res = '0;
  logic         m_err = 1'b0;
  logic [W-1:0] m_a = '0, m_b = '0;
  int           m_ptr = 0;

  always @(posedge clk) begin
    logic [N-1:0] n_gnt;
    logic [N-1:0] n_done;
    logic [2:0]   n_res;
    n_gnt = '0; n_done = '0; n_res = '0;
    if (rst) begin
      m_err = 1'b0; m_a = '0; m_b = '0; m_ptr = 0;
    end else if (m_gnt != '0) begin
      n_done = m_gnt;
      if (fault) n_res = 3'b110;
      else n_res = {m_a < m_b, m_a == m_b, m_a > m_b};
      if ($countones(n_res) != 1) m_err = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
`ifdef CMP_ARB_FIXED_PRIO_EN
        i = k;
`else
        i = (m_ptr + k) % N;
`endif
        if (n_gnt == '0 && ifc.req[i]) begin
          n_gnt = N'(1) << i;
          m_a = ifc.req_a[i*W +: W];
          m_b = ifc.req_b[i*W +: W];
`ifdef CMP_ARB_FIXED_PRIO_EN
          m_ptr = 0;
`else
          m_ptr = (i + 1) % N;
`endif
        end
      end
    end
    m_gnt = n_gnt; m_done = n_done; m_res = n_res;
  end

  always @(posedge clk) begin
    #1;
    chk("m_gnt", ifc.gnt, m_gnt);
    chk("m_done", ifc.done, m_done);
    chk("m_res", {ifc.res_lt, ifc.res_eq, ifc.res_gt}, m_res);
    chk("m_err", ifc.err, m_err);
    chk("m_cmp_a", ifc.cmp_a, m_a);
    chk("m_cmp_b", ifc.cmp_b, m_b);
    chk("gnt_done_excl", (ifc.gnt != '0) && (ifc.done != '0), 1'b0);
  end

  // Requesters drop req once they see their grant unless told to hold.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (ifc.gnt[i] && !hold[i]) ifc.req[i] = 1'b0;
  end

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    ifc.req_a[i*W +: W] = a;
    ifc.req_b[i*W +: W] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ifc.req = '0; hold = '0; fault = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    ifc.req = '0; ifc.req_a = '0; ifc.req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", ifc.gnt, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_err", ifc.err, 0);
    chk("rst_cmp_a", ifc.cmp_a, 0);
    @(negedge clk);
    rst = 1'b0;

    // single request
    set_op(2, 4'd5, 4'd9); ifc.req[2] = 1'b1;
    tick(); chk("single_gnt", ifc.gnt, 4'b0100); chk("single_cmp_a", ifc.cmp_a, 5);
    chk("single_cmp_b", ifc.cmp_b, 9);
    tick(); chk("single_done", ifc.done, 4'b0100); chk("single_lt", ifc.res_lt, 1);
    tick(); chk("single_idle", {ifc.gnt, ifc.done}, 0); chk("single_hold_a", ifc.cmp_a, 5);

    // all four at once
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 4'd7, 4'd7);
    ifc.req = 4'hF;
    for (int k = 0; k < N; k++) begin
      tick(); chk("all_gnt", ifc.gnt, 32'(1) << k);
      tick(); chk("all_done", ifc.done, 32'(1) << k); chk("all_eq", ifc.res_eq, 1);
    end
    tick(); chk("all_idle", ifc.gnt, 0);
    @(negedge clk);
    ifc.req[0] = 1'b1; ifc.req[1] = 1'b1;
    tick(); chk("ptr_wrap_gnt", ifc.gnt, 4'b0001);
    repeat (4) tick();

    // back-to-back
    do_reset();
    set_op(0, 4'd12, 4'd3); set_op(1, 4'd0, 4'd15);
    ifc.req[0] = 1'b1; ifc.req[1] = 1'b1;
    tick(); chk("b2b_gnt0", ifc.gnt, 4'b0001);
    tick(); chk("b2b_done0", ifc.done, 4'b0001); chk("b2b_gt", ifc.res_gt, 1);
    tick(); chk("b2b_gnt1", ifc.gnt, 4'b0010);
    tick(); chk("b2b_done1", ifc.done, 4'b0010); chk("b2b_lt", ifc.res_lt, 1);

    // faulty comparator
    do_reset();
    fault = 1'b1; set_op(2, 4'd3, 4'd3); ifc.req[2] = 1'b1;
    tick(); chk("flt_gnt", ifc.gnt, 4'b0100); chk("flt_err_pre", ifc.err, 0);
    tick(); chk("flt_err", ifc.err, 1); chk("flt_res", {ifc.res_lt, ifc.res_eq, ifc.res_gt}, 3'b110);
    @(negedge clk);
    fault = 1'b0; set_op(1, 4'd2, 4'd8); ifc.req[1] = 1'b1;
    tick(); tick(); chk("flt_legal_lt", ifc.res_lt, 1); chk("flt_sticky", ifc.err, 1);
    do_reset();
    #1; chk("flt_cleared", ifc.err, 0);

    // reset during CMP
    set_op(1, 4'd1, 4'd2); ifc.req[1] = 1'b1;
    tick(); chk("abort_gnt", ifc.gnt, 4'b0010);
    @(negedge clk); rst = 1'b1;
    tick(); chk("abort_out", {ifc.gnt, ifc.done, ifc.err, ifc.cmp_a, ifc.cmp_b}, 0);
    @(negedge clk); rst = 1'b0;
    set_op(3, 4'd9, 4'd4); ifc.req[3] = 1'b1;
    tick(); chk("abort_done", ifc.done, 0); chk("fresh_gnt", ifc.gnt, 4'b1000);
    tick(); chk("fresh_done", ifc.done, 4'b1000); chk("fresh_gt", ifc.res_gt, 1);

    // requester 0 re-requests continuously while requester 1 waits
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 4'(i), 4'd3);
    hold[0] = 1'b1; ifc.req[0] = 1'b1; ifc.req[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
`ifdef CMP_ARB_FIXED_PRIO_EN
      chk("prio_gnt", ifc.gnt, 4'b0001);
`else
      chk("rr_gnt", ifc.gnt, (k == 1) ? 4'b0010 : 4'b0001);
`endif
      tick();
    end
    @(negedge clk);
    hold = '0; ifc.req = '0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
